serial_tx: RTL and testbench

- Bit-serial frame transmitter. Takes a parallel word through a valid/ready handshake and shifts it out on a single line: start bit, data bits LSB first, optional parity bit, stop bit.
- It is the driving end of the lab's serial link. It produces the bit stream that the d_ff-based shift-register receivers sample.
- It sits between a parallel producer (register file / test stimulus) and the single-wire serial output.

---
 rtl/serial_tx.sv | 166 ++++++++++++++++
 tb/tb_serial_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Bit-serial frame transmitter: accepts a parallel word on a valid/ready handshake,
// then sends start bit, data LSB first, optional parity bit and stop bit.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);
  localparam logic              PAR_ON    = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              baud_end;

  assign baud_end = (baud_q == LAST_BAUD);

  // Outputs are computed one cycle ahead from the next state so that the
  // registered line changes only at bit boundaries.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_out_d   = tx_out_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ PAR_ODD;
          baud_d     = '0;
          bit_d      = '0;
          state_d    = S_START;
          tx_out_d   = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_START: begin
        if (baud_end) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = S_DATA;
          tx_out_d = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            if (PAR_ON) begin
              state_d  = S_PARITY;
              tx_out_d = par_q;
            end else begin
              state_d  = S_STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            tx_out_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_PARITY: begin
        if (baud_end) begin
          baud_d   = '0;
          state_d  = S_STOP;
          tx_out_d = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (baud_end) begin
          baud_d     = '0;
          state_d    = S_IDLE;
          tx_out_d   = 1'b1;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_d     = '0;
        bit_d      = '0;
        tx_out_d   = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the shift register is reset too, as it is small and
  // a cleared value keeps post-reset behaviour fully deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four parameterisations, per-cycle expected line
// state queued when a frame is launched and popped as the DUT runs.
module tb_serial_tx;

  typedef struct packed {
    logic out;
    logic busy;
    logic ready;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [3:0] d3 = '0;
  logic       r0, r1, r2, r3;
  logic       o0, o1, o2, o3;
  logic       b0, b1, b2, b3;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: odd parity, 2: no parity, 3: WIDTH=4 with one clock per bit
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
    .clk(clk), .reset(reset), .tx_valid(v0), .tx_data(d0),
    .tx_ready(r0), .tx_out(o0), .busy(b0));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .tx_valid(v1), .tx_data(d1),
    .tx_ready(r1), .tx_out(o1), .busy(b1));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .reset(reset), .tx_valid(v2), .tx_data(d2),
    .tx_ready(r2), .tx_out(o2), .busy(b2));
  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_fast (
    .clk(clk), .reset(reset), .tx_valid(v3), .tx_data(d3),
    .tx_ready(r3), .tx_out(o3), .busy(b3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t observe(input int id);
    case (id)
      0: return {o0, b0, r0};
      1: return {o1, b1, r1};
      2: return {o2, b2, r2};
      default: return {o3, b3, r3};
    endcase
  endfunction

  task automatic drive(input int id, input logic v, input logic [7:0] data);
    case (id)
      0: begin v0 = v; d0 = data; end
      1: begin v1 = v; d1 = data; end
      2: begin v2 = v; d2 = data; end
      default: begin v3 = v; d3 = data[3:0]; end
    endcase
  endtask

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{out: 1'b1, busy: 1'b0, ready: 1'b1});
  endfunction

  function automatic void push_bit(input logic b, input int cpb);
    for (int i = 0; i < cpb; i++) exp_q.push_back('{out: b, busy: 1'b1, ready: 1'b0});
  endfunction

  // Reference frame built straight from the frame format, independent of the RTL.
  function automatic void push_frame(input int w, input int cpb, input int pe,
                                     input int po, input logic [7:0] data);
    logic par;
    par = (po != 0);
    push_bit(1'b0, cpb);
    for (int i = 0; i < w; i++) begin
      push_bit(data[i], cpb);
      par = par ^ data[i];
    end
    if (pe != 0) push_bit(par, cpb);
    push_bit(1'b1, cpb);
  endfunction

  function automatic void push_for(input int id, input logic [7:0] data);
    case (id)
      0: push_frame(8, 4, 1, 0, data);
      1: push_frame(8, 4, 1, 1, data);
      2: push_frame(8, 4, 0, 0, data);
      default: push_frame(4, 1, 1, 0, data);
    endcase
  endfunction

  // mode 0: plain frame; 1: valid held for a second word (second data passed in);
  // 2: spurious valid/data activity while busy; 3: reset asserted mid-DATA.
  task automatic send(input string name, input int id, input logic [7:0] data,
                      input int mode, input logic [7:0] data2);
    exp_t e, o;
    int   i;
    bit   stop;
    drive(id, 1'b1, data);
    push_for(id, data);
    if (mode == 1) begin
      push_idle(1);
      push_for(id, data2);
    end
    push_idle(mode == 2 ? 3 : 1);
    tick();
    if (mode != 1) drive(id, 1'b0, data);
    i = 0;
    stop = 0;
    while (exp_q.size() > 0 && !stop) begin
      e = exp_q.pop_front();
      o = observe(id);
      check($sformatf("%s out[%0d]", name, i), o.out, e.out);
      check($sformatf("%s busy[%0d]", name, i), o.busy, e.busy);
      check($sformatf("%s ready[%0d]", name, i), o.ready, e.ready);
      if (mode == 1) begin
        if (i == 0) drive(id, 1'b1, data2);
        if (i == 45) drive(id, 1'b0, 8'h00);
      end
      if (mode == 2) begin
        if (i == 10) drive(id, 1'b1, 8'h12);
        if (i == 11) drive(id, 1'b0, 8'h12);
        if (i == 20) drive(id, 1'b0, 8'hFF);
        if (i == 30) drive(id, 1'b0, 8'h00);
      end
      if (mode == 3 && i == 16) begin
        #2 reset = 1'b0;
        #1;
        o = observe(id);
        check($sformatf("%s rst out", name), o.out, 1'b1);
        check($sformatf("%s rst busy", name), o.busy, 1'b0);
        check($sformatf("%s rst ready", name), o.ready, 1'b1);
        exp_q.delete();
        stop = 1;
      end else begin
        tick();
      end
      i++;
    end
  endtask

  initial begin
    exp_t o;
    tick();
    tick();
    for (int id = 0; id < 4; id++) begin
      o = observe(id);
      check($sformatf("reset out%0d", id), o.out, 1'b1);
      check($sformatf("reset busy%0d", id), o.busy, 1'b0);
      check($sformatf("reset ready%0d", id), o.ready, 1'b1);
    end
    reset = 1'b1;
    tick();

    send("a5", 0, 8'hA5, 0, 8'h00);
    send("odd00", 1, 8'h00, 0, 8'h00);
    send("nopar00", 2, 8'h00, 0, 8'h00);
    send("b2b", 0, 8'h3C, 1, 8'hFF);
    tick();
    send("busy", 0, 8'h5A, 2, 8'h00);
    send("midrst", 0, 8'hC3, 3, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    o = observe(0);
    check("post rst out", o.out, 1'b1);
    check("post rst ready", o.ready, 1'b1);
    send("x81", 0, 8'h81, 0, 8'h00);
    send("fast", 3, 8'h06, 0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
